// File: rtl/serial_link_pkg.sv
// Shared constants and state types for the single-wire ADC frame link.
// Used by both the slave-side serializer and the master-side receiver.
package serial_link_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int FRAME_BITS = 2 * WORD_W_DEF + 2;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for an asynchronous line that idles high.
// Presets to the idle level so reset never looks like a start bit.
module bit_synchronizer
    import serial_link_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/serial_frame_receiver.sv
// Recovers start/payload/stop frames from one slave lane and holds
// each good lower/upper word pair behind a valid/ready register.
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int WORD_W       = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              serial_in,
    output logic [WORD_W-1:0] lower_word,
    output logic [WORD_W-1:0] upper_word,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              framing_error,
    output logic              overrun,
    output logic [15:0]       frame_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = 2 * WORD_W;
    localparam int IW = $clog2(PW);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(PW - 1);

    logic              s;
    rx_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     bit_q;
    logic [PW-1:0]     shift_q;
    logic              commit_q;
    logic [WORD_W-1:0] lower_q;
    logic [WORD_W-1:0] upper_q;
    logic              valid_q;
    logic              ferr_q;
    logic              ovr_q;
    logic [15:0]       count_q;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .reset (reset),
        .d_i   (serial_in),
        .q_o   (s)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            commit_q <= 1'b0;
            lower_q  <= '0;
            upper_q  <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            commit_q <= 1'b0;
            cnt_q    <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;

            if (!enable && state_q != RX_IDLE) begin
                state_q <= RX_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    RX_IDLE: begin
                        if (enable && s == START_LEVEL) begin
                            state_q <= RX_START;
                            cnt_q   <= '0;
                        end
                    end
                    RX_START: begin
                        // mid-bit recheck rejects short glitches
                        if (cnt_q == HALF_CNT) begin
                            cnt_q <= '0;
                            bit_q <= '0;
                            state_q <= (s == START_LEVEL) ? RX_DATA : RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        if (cnt_q == LAST_CNT) begin
                            shift_q <= {shift_q[PW-2:0], s};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == LAST_BIT) begin
                                state_q <= RX_STOP;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q <= '0;
                            if (s == STOP_LEVEL) begin
                                commit_q <= 1'b1;
                                state_q  <= RX_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= RX_WAIT_HIGH;
                            end
                        end
                    end
                    RX_WAIT_HIGH: begin
                        if (s == IDLE_LEVEL) begin
                            state_q <= RX_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end

            // a frame landing on a full, unaccepted register is dropped
            if (commit_q) begin
                if (!valid_q || data_ready) begin
                    lower_q <= shift_q[PW-1:WORD_W];
                    upper_q <= shift_q[WORD_W-1:0];
                    valid_q <= 1'b1;
                    count_q <= count_q + 16'd1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign lower_word    = lower_q;
    assign upper_word    = upper_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign frame_count   = count_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized and directed bench for serial_frame_receiver against a
// frame-level model: queues of sent words and expected counters.
module tb_serial_frame_receiver;

    localparam int CPB  = 4;
    localparam int W    = 16;
    localparam int SYNC = 2;
    // line start-bit drive edge to commit edge: sync, idle detect,
    // half-bit sample, 2W data bits plus stop bit, commit register
    localparam int COMMIT_EDGE = SYNC + (CPB / 2 - 1) + 3 + CPB * (2 * W + 1);

    logic          clk_in = 1'b0;
    logic          reset;
    logic          enable;
    logic          serial_in;
    logic [W-1:0]  lower_word;
    logic [W-1:0]  upper_word;
    logic          data_valid;
    logic          data_ready;
    logic          framing_error;
    logic          overrun;
    logic [15:0]   frame_count;

    int checks = 0;
    int errors = 0;

    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int dv_hi_cnt = 0;
    int dv_lo_cnt = 0;
    logic [31:0] acc_q[$];

    serial_frame_receiver #(
        .CLKS_PER_BIT(CPB),
        .WORD_W      (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .serial_in    (serial_in),
        .lower_word   (lower_word),
        .upper_word   (upper_word),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (framing_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (framing_error && overrun) both_cnt++;
        if (data_valid) dv_hi_cnt++;
        else dv_lo_cnt++;
        if (data_valid && data_ready) acc_q.push_back({lower_word, upper_word});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [W-1:0] lo, input logic [W-1:0] up,
                              input logic stop);
        logic [2*W-1:0] pay;
        pay = {lo, up};
        send_bit(1'b0);
        for (int i = 2 * W - 1; i >= 0; i--) send_bit(pay[i]);
        send_bit(stop);
    endtask

    initial begin
        int fe0, ov0, hi0, lo0, rd;
        logic [15:0] exp_cnt;
        logic [31:0] exp_q[$];

        reset = 1'b1;
        enable = 1'b0;
        serial_in = 1'b1;
        data_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        @(negedge clk_in);
        check("rst_valid", data_valid, 0);
        check("rst_words", {lower_word, upper_word}, 0);
        check("rst_count", frame_count, 0);
        check("rst_flags", {framing_error, overrun}, 0);
        tick(1);
        enable = 1'b1;
        exp_cnt = 0;

        // nominal frame with consumer ready
        data_ready = 1'b1;
        hi0 = dv_hi_cnt; rd = acc_q.size();
        send_frame(16'hA5C3, 16'h1234, 1'b1);
        tick(6);
        exp_cnt++;
        check("nom_pulse", dv_hi_cnt - hi0, 1);
        check("nom_acc_n", acc_q.size() - rd, 1);
        if (acc_q.size() > rd) check("nom_words", acc_q[rd], 32'hA5C3_1234);
        check("nom_count", frame_count, exp_cnt);
        check("nom_clear", data_valid, 0);

        // one-cycle glitch on idle line
        fe0 = fe_cnt; hi0 = dv_hi_cnt;
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(12);
        check("gl_valid", dv_hi_cnt - hi0, 0);
        check("gl_ferr", fe_cnt - fe0, 0);
        check("gl_count", frame_count, exp_cnt);

        // bad stop bit, line stuck low, then recovery
        fe0 = fe_cnt; hi0 = dv_hi_cnt;
        send_frame(16'hFFFF, 16'h0001, 1'b0);
        tick(20);
        serial_in = 1'b1;
        tick(10);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_novalid", dv_hi_cnt - hi0, 0);
        check("fe_count", frame_count, exp_cnt);
        rd = acc_q.size();
        send_frame(16'h0F0F, 16'hF0F0, 1'b1);
        tick(6);
        exp_cnt++;
        check("fe_recov_n", acc_q.size() - rd, 1);
        if (acc_q.size() > rd) check("fe_recov", acc_q[rd], 32'h0F0F_F0F0);
        check("fe_recov_cnt", frame_count, exp_cnt);

        // back-to-back frames with consumer stalled
        data_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(16'h1111, 16'h2222, 1'b1);
        send_frame(16'h3333, 16'h4444, 1'b1);
        tick(8);
        exp_cnt++;
        check("ov_valid", data_valid, 1);
        check("ov_words", {lower_word, upper_word}, 32'h1111_2222);
        check("ov_pulse", ov_cnt - ov0, 1);
        check("ov_count", frame_count, exp_cnt);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        @(negedge clk_in);
        check("ov_accept", data_valid, 0);
        tick(1);

        // commit in the same cycle as an acceptance
        send_frame(16'h5555, 16'h6666, 1'b1);
        tick(8);
        exp_cnt++;
        check("co_first", {lower_word, upper_word}, 32'h5555_6666);
        ov0 = ov_cnt; lo0 = dv_lo_cnt;
        fork
            send_frame(16'h7777, 16'h8888, 1'b1);
            begin
                tick(COMMIT_EDGE - 1);
                data_ready = 1'b1;
                tick(1);
                data_ready = 1'b0;
            end
        join
        tick(4);
        exp_cnt++;
        check("co_nodip", dv_lo_cnt - lo0, 0);
        check("co_valid", data_valid, 1);
        check("co_words", {lower_word, upper_word}, 32'h7777_8888);
        check("co_count", frame_count, exp_cnt);
        check("co_noovr", ov_cnt - ov0, 0);

        // reset in the middle of a frame
        fork
            send_frame(16'hBBBB, 16'hCCCC, 1'b1);
            begin
                tick(60);
                reset = 1'b1;
            end
        join
        tick(2);
        reset = 1'b0;
        tick(6);
        exp_cnt = 0;
        check("mr_valid", data_valid, 0);
        check("mr_words", {lower_word, upper_word}, 0);
        check("mr_count", frame_count, exp_cnt);
        check("mr_flags", {framing_error, overrun}, 0);

        // enable dropped in the middle of a frame
        send_frame(16'hDDDD, 16'hEEEE, 1'b1);
        tick(6);
        exp_cnt++;
        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            send_frame(16'h1357, 16'h2468, 1'b1);
            begin
                tick(60);
                enable = 1'b0;
            end
        join
        tick(4);
        enable = 1'b1;
        tick(4);
        check("en_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("en_hold", {lower_word, upper_word}, 32'hDDDD_EEEE);
        check("en_valid", data_valid, 1);
        check("en_count", frame_count, exp_cnt);
        data_ready = 1'b1;
        tick(2);
        rd = acc_q.size();
        send_frame(16'h0BAD, 16'hF00D, 1'b1);
        tick(6);
        exp_cnt++;
        check("en_next_n", acc_q.size() - rd, 1);
        if (acc_q.size() > rd) check("en_next", acc_q[rd], 32'h0BAD_F00D);
        check("en_next_cnt", frame_count, exp_cnt);

        // random frames and gaps, consumer always ready
        fe0 = fe_cnt; ov0 = ov_cnt; rd = acc_q.size();
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] lo;
            logic [W-1:0] up;
            lo = W'($urandom);
            up = W'($urandom);
            exp_q.push_back({lo, up});
            tick($urandom_range(0, 7));
            send_frame(lo, up, 1'b1);
            exp_cnt++;
        end
        tick(8);
        check("rnd_n", acc_q.size() - rd, exp_q.size());
        foreach (exp_q[i]) begin
            if (rd + i < acc_q.size()) check($sformatf("rnd_w%0d", i), acc_q[rd + i], exp_q[i]);
        end
        check("rnd_count", frame_count, exp_cnt);
        check("rnd_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("no_coincide", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive side of the single-wire frame link driven by the ADC data serializer on each slave FPGA.
- Recovers one frame at a time from an asynchronous serial line. Each frame carries a 16-bit lower-ADC word and a 16-bit upper-ADC word.
- Presents each recovered pair through a valid/ready holding register.
- The data aggregator instantiates one receiver per slave lane (serial_data1..4) in the master FPGA.

Parameters:
- CLKS_PER_BIT, 4, clk_in cycles per serial bit; legal values are >= 2.
- WORD_W, 16, width of each ADC word; a frame carries 2*WORD_W payload bits.
- SYNC_STAGES, 2, number of input synchronizer flops; legal values are >= 2.

Ports:
- clk_in  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  receiver armed; low aborts any frame in progress
- serial_in  in  1  asynchronous serial line, idles high
- lower_word  out  WORD_W  first payload word of the held frame
- upper_word  out  WORD_W  second payload word of the held frame
- data_valid  out  1  held frame available
- data_ready  in  1  consumer accepts the held frame
- framing_error  out  1  one-cycle pulse when a stop bit is bad
- overrun  out  1  one-cycle pulse when a good frame is dropped
- frame_count  out  16  count of frames committed to the holding register, wrapping

Behaviour:
- Frame format, in line order:
  - start bit 0;
  - lower_word, MSB first;
  - upper_word, MSB first;
  - stop bit 1.
  - Total length is 2*WORD_W+2 bit periods.
- serial_in passes through SYNC_STAGES flops, which preset to 1 on reset. All decisions use the synchronized bit s.
- Bit period counter:
  - Width is clog2(CLKS_PER_BIT).
  - Cleared on every state entry.
  - Sample point is count == CLKS_PER_BIT/2-1 (floor) within the start bit; after that, every CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when enable=1 and s=0, go to START.
- START: at the half-bit sample:
  - s=1 means a glitch: return to IDLE with no flags;
  - s=0: go to DATA with bit index 0.
- DATA:
  - Shift s into a 2*WORD_W shift register at each sample.
  - After sample 2*WORD_W-1, go to STOP.
- STOP: at the sample:
  - s=1: commit the frame and go to IDLE;
  - s=0: pulse framing_error and go to WAIT_HIGH.
- WAIT_HIGH: stay until s=1, then go to IDLE. Prevents re-triggering on a stuck-low line.
- Commit, on the cycle after the stop sample:
  - data_valid=0, or data_valid=1 with data_ready=1 in the commit cycle: load the words, set data_valid=1, increment frame_count.
  - data_valid=1 with data_ready=0: held words are unchanged, overrun pulses for 1 cycle, frame_count is unchanged.
- Handshake:
  - data_valid clears on the cycle after data_valid && data_ready, unless a commit occurs in the same cycle.
  - Held words are stable while data_valid=1.
- Latency: the stop-bit sample edge to data_valid high is 1 cycle. The line edge to s is SYNC_STAGES cycles.
- frame_count wraps from 0xFFFF to 0x0000.
- enable=0 in any non-IDLE state: return to IDLE next cycle. No flags; held outputs and frame_count are unaffected.
- Reset, including mid-frame: FSM to IDLE, shift register and words 0, data_valid=0, framing_error=0, overrun=0, frame_count=0.
- framing_error and overrun never assert in the same cycle.

Decomposition:
- Shared package serial_link_pkg holds:
  - frame constants (FRAME_BITS = 2*WORD_W+2, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1);
  - the rx state enum.
- The same package also serves the data serializer.
- One natural sub-module: bit_synchronizer (SYNC_STAGES flop chain with preset-high reset).

Test Plan:
- Nominal frame (CLKS_PER_BIT=4), lower=0xA5C3, upper=0x1234, data_ready=1 -> data_valid pulses 1 cycle, lower_word=0xA5C3, upper_word=0x1234, frame_count=1.
- One-cycle low glitch on an idle line -> FSM returns to IDLE after the half-bit sample; data_valid, framing_error and frame_count stay 0.
- Frame 0xFFFF/0x0001 with the stop bit forced 0, then line held low for 20 cycles, then high -> one framing_error pulse, no data_valid. A subsequent good frame 0x0F0F/0xF0F0 is received correctly.
- Two back-to-back frames 0x1111/0x2222 then 0x3333/0x4444 with data_ready=0 -> the held words stay 0x1111/0x2222, overrun pulses once, frame_count=1. Raising data_ready clears data_valid.
- Commit coinciding with a data_ready acceptance -> data_valid stays 1, the new words are loaded, frame_count increments by 1.
- reset asserted mid-DATA, and separately enable dropped mid-DATA -> reset: all outputs 0. enable drop: no flags, the prior held frame is retained, and the next full frame is received correctly.
